// File: rtl/controller.sv
// controller: multicycle control unit for the 8-bit MIPS core.
// Moore FSM; the per-state control word is registered together with the
// state, so every output except pcen and alucontrol comes straight from flops.
// Optional feature: define CTRL_ADDI_EN to add the ADDIEX/ADDIWR states.
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic [2:0] alucontrol
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
`ifdef CTRL_ADDI_EN
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
`else
        JEX     = 4'd12
`endif
    } state_t;

    // Control word for one state; pcwrite/branch/aluop are internal only.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic [3:0] irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctl_t;

    state_t r_state;
    ctl_t   r_ctl;
    ctl_t   w_ctl;

    // Successor of a state; op only matters in DECODE and MEMADR.
    function automatic state_t next_state(input state_t s, input logic [5:0] opc);
        state_t n;
        n = FETCH1;
        case (s)
            FETCH1:  n = FETCH2;
            FETCH2:  n = FETCH3;
            FETCH3:  n = FETCH4;
            FETCH4:  n = DECODE;
            DECODE: begin
                case (opc)
                    OP_LB, OP_SB: n = MEMADR;
                    OP_RTYPE:     n = RTYPEEX;
                    OP_BEQ:       n = BEQEX;
                    OP_J:         n = JEX;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      n = ADDIEX;
`endif
                    default:      n = FETCH1;
                endcase
            end
            MEMADR:  n = (opc == OP_LB) ? LBRD : SBWR;
            LBRD:    n = LBWR;
            RTYPEEX: n = RTYPEWR;
`ifdef CTRL_ADDI_EN
            ADDIEX:  n = ADDIWR;
`endif
            default: n = FETCH1;
        endcase
        return n;
    endfunction

    // Control word asserted while sitting in a state; unlisted fields stay 0.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BEQEX: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b01;
                c.branch   = 1'b1;
                c.pcsource = 2'b01;
            end
            JEX: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
`ifdef CTRL_ADDI_EN
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWR:  c.regwrite = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // ALU operation from aluop, decoding funct for R-type execution.
    function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [5:0] fn);
        logic [2:0] a;
        a = 3'b010;
        case (aop)
            2'b01: a = 3'b110;
            2'b10: begin
                case (fn)
                    6'b100010: a = 3'b110;
                    6'b100100: a = 3'b000;
                    6'b100101: a = 3'b001;
                    6'b101010: a = 3'b111;
                    default:   a = 3'b010;
                endcase
            end
            default: a = 3'b010;
        endcase
        return a;
    endfunction

    // State register with the control word of the state being entered.
    // NOTE: non-blocking assignments keep state and control word updating
    // together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH1;
            r_ctl   <= state_ctl(FETCH1);
        end else begin
            r_state <= next_state(r_state, op);
            r_ctl   <= state_ctl(next_state(r_state, op));
        end
    end

    // Reset blanks every output immediately so an aborted instruction cannot
    // write memory or the register file during the reset cycle.
    assign w_ctl = reset ? '0 : r_ctl;

    assign memread    = w_ctl.memread;
    assign memwrite   = w_ctl.memwrite;
    assign alusrca    = w_ctl.alusrca;
    assign alusrcb    = w_ctl.alusrcb;
    assign iord       = w_ctl.iord;
    assign irwrite    = w_ctl.irwrite;
    assign memtoreg   = w_ctl.memtoreg;
    assign regdst     = w_ctl.regdst;
    assign regwrite   = w_ctl.regwrite;
    assign pcsource   = w_ctl.pcsource;
    assign pcen       = w_ctl.pcwrite | (w_ctl.branch & zero);
    assign alucontrol = reset ? 3'b000 : alu_decode(w_ctl.aluop, funct);

endmodule

// File: tb/tb_controller.sv
// Bench for controller: random instruction stream checked cycle by cycle
// against a per-instruction timeline model of the control outputs.
module tb_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;

    int checks = 0;
    int errors = 0;

    controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .iord(iord), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .pcsource(pcsource), .pcen(pcen), .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic [3:0] irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] pcsource;
        logic       pcen;
        logic [2:0] alucontrol;
    } obs_t;

    typedef enum int {C_LB, C_SB, C_R, C_BEQ, C_J, C_ADDI, C_ILL} cls_t;

    function automatic obs_t sample();
        obs_t o;
        o = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
             memtoreg, regdst, regwrite, pcsource, pcen, alucontrol};
        return o;
    endfunction

    function automatic logic addi_enabled();
`ifdef CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Total cycles an instruction of this class takes, fetch included.
    function automatic int instr_len(input cls_t c);
        case (c)
            C_LB:   return 8;
            C_SB, C_R: return 7;
            C_ADDI: return addi_enabled() ? 7 : 5;
            C_BEQ, C_J: return 6;
            default: return 5;
        endcase
    endfunction

    function automatic logic [5:0] class_op(input cls_t c);
        logic [5:0] v;
        case (c)
            C_LB:   return 6'b100000;
            C_SB:   return 6'b101000;
            C_R:    return 6'b000000;
            C_BEQ:  return 6'b000100;
            C_J:    return 6'b000010;
            C_ADDI: return 6'b001000;
            default: begin
                v = 6'($urandom);
                if (v inside {6'b100000, 6'b101000, 6'b000000,
                              6'b000100, 6'b000010, 6'b001000})
                    v = 6'b111111;
                return v;
            end
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs on cycle idx of an instruction of class c.
    function automatic obs_t model(input cls_t c, input int idx,
                                   input logic [5:0] fn, input logic z);
        obs_t e;
        e = '0;
        e.alucontrol = 3'b010;
        if (idx < 4) begin
            e.memread = 1'b1;
            e.alusrcb = 2'b01;
            e.pcen    = 1'b1;
            e.irwrite = 4'(1 << idx);
        end else if (idx == 4) begin
            e.alusrcb = 2'b11;
        end else begin
            case (c)
                C_LB, C_SB, C_ADDI: begin
                    if (idx == 5) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else if (c == C_ADDI) begin
                        e.regwrite = 1'b1;
                    end else if (c == C_SB) begin
                        e.memwrite = 1'b1;
                        e.iord     = 1'b1;
                    end else if (idx == 6) begin
                        e.memread = 1'b1;
                        e.iord    = 1'b1;
                    end else begin
                        e.regwrite = 1'b1;
                        e.memtoreg = 1'b1;
                    end
                end
                C_R: begin
                    if (idx == 5) begin
                        e.alusrca    = 1'b1;
                        e.alucontrol = rtype_alu(fn);
                    end else begin
                        e.regwrite = 1'b1;
                        e.regdst   = 1'b1;
                    end
                end
                C_BEQ: begin
                    e.alusrca    = 1'b1;
                    e.alucontrol = 3'b110;
                    e.pcsource   = 2'b01;
                    e.pcen       = z;
                end
                C_J: begin
                    e.pcen     = 1'b1;
                    e.pcsource = 2'b10;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs the first ncycles cycles of one instruction; starts and ends
    // 1 time unit after a rising edge.
    task automatic run_instr(input cls_t c, input logic [5:0] fn, input int ncycles);
        op    = class_op(c);
        funct = fn;
        for (int idx = 0; idx < ncycles; idx++) begin
            zero = 1'($urandom);
            @(negedge clk);
            check($sformatf("%s op=%b cyc%0d", c.name(), op, idx), sample(),
                  model(c, idx, fn, zero));
            if (c == C_BEQ && idx == 5) begin
                zero = ~zero;
                #1;
                check("beq_zero_toggle", sample(), model(c, idx, fn, zero));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] rfuncts [5];
        cls_t       c;
        logic [5:0] fn;
        rfuncts = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset held two cycles: all outputs zero even with zero=1.
        reset = 1'b1;
        op    = 6'b101010;
        funct = 6'b0;
        zero  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_hold", sample(), obs_t'('0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Illegal opcode: fetch, decode, back to FETCH1.
        run_instr(C_ILL, 6'b0, 5);

        // Directed: each instruction class once, every R-type funct.
        run_instr(C_LB, 6'($urandom), 8);
        run_instr(C_SB, 6'($urandom), 7);
        for (int i = 0; i < 5; i++) run_instr(C_R, rfuncts[i], 7);
        run_instr(C_R, 6'b111111, 7);
        run_instr(C_BEQ, 6'($urandom), 6);
        run_instr(C_BEQ, 6'($urandom), 6);
        run_instr(C_J, 6'($urandom), 6);
        run_instr(C_ADDI, 6'($urandom), instr_len(C_ADDI));

        // Reset asserted in LBRD aborts the load.
        run_instr(C_LB, 6'($urandom), 6);
        reset = 1'b1;
        zero  = 1'b1;
        @(negedge clk);
        check("reset_in_lbrd", sample(), obs_t'('0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(C_SB, 6'($urandom), 7);

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            c  = cls_t'($urandom_range(0, 6));
            fn = ($urandom_range(0, 3) != 0) ? rfuncts[$urandom_range(0, 4)]
                                              : 6'($urandom);
            run_instr(c, fn, instr_len(c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
